shift_register_n: RTL

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal register with per-cycle mode control (hold/load/shift/rotate/clear) and a built-in serialiser FSM. A `start` pulse shifts a parallel word out on `ser_out` while capturing `ser_in`. It is the general-purpose storage/serdes primitive for datapath and bring-up benches, and it replaces ad-hoc flip-flop chains.

---
 rtl/shift_register_pkg.sv | 20 ++
 rtl/shift_register_n.sv | 98 +++++++++
 2 files changed

// File: rtl/shift_register_pkg.sv
// Shared types for the shift_register_n universal register / serialiser.
package shift_register_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_SHL   = 3'd2,
    MODE_SHR   = 3'd3,
    MODE_ROL   = 3'd4,
    MODE_ROR   = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_RSVD  = 3'd7
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_register_n.sv
// WIDTH-bit universal register (hold/load/shift/rotate/clear) with a built-in
// serialiser that shifts a loaded word out on ser_out while capturing ser_in.
module shift_register_n
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic             done_q,  done_d;

  function automatic logic [WIDTH-1:0] mode_next(
    input mode_e            m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sin
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (m)
      MODE_LOAD:  nxt = din;
      MODE_SHL:   nxt = {cur[WIDTH-2:0], sin};
      MODE_SHR:   nxt = {sin, cur[WIDTH-1:1]};
      MODE_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_CLEAR: nxt = '0;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start has priority over en/mode so a request is never lost
        if (start) begin
          q_d     = d;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (en) begin
          q_d = mode_next(mode_e'(mode), q_q, d, ser_in);
        end
      end
      ST_SHIFT: begin
        if (en) begin
          q_d   = MSB_FIRST ? {q_q[WIDTH-2:0], ser_in} : {ser_in, q_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];
  assign busy    = (state_q == ST_SHIFT);
  assign done    = done_q;

endmodule
